// File: rtl/regfile_sb.sv
// picoMIPS register file (DEPTH x N, 1W/2R) with a write-back scoreboard for multi-cycle results.
// Optional same-cycle write-to-read forwarding is enabled by defining REGS_BYPASS_EN.
module regfile_sb #(
    parameter int N        = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 1,
    parameter int TAP0_IDX = 2,
    parameter int TAP1_IDX = 3,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [N-1:0]        wdata,
    input  logic [AW-1:0]       raddr1,
    input  logic [AW-1:0]       raddr2,
    output logic signed [N-1:0] rdata1,
    output logic signed [N-1:0] rdata2,
    input  logic                issue,
    input  logic [AW-1:0]       issue_addr,
    output logic                busy1,
    output logic                busy2,
    output logic                stall,
    output logic signed [N-1:0] tap0,
    output logic signed [N-1:0] tap1
);

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic          ZR_EN   = (ZERO_REG != 0);
    localparam logic [AW-1:0] TAP0_A  = AW'(TAP0_IDX);
    localparam logic [AW-1:0] TAP1_A  = AW'(TAP1_IDX);

    logic [DEPTH-1:0][N-1:0] regs_q;
    logic [DEPTH-1:0][N-1:0] regs_d;
    logic [DEPTH-1:0]        pending_q;
    logic [DEPTH-1:0]        pending_d;

    logic                    wr_ok_s;
    logic                    iss_ok_s;
    logic [1:0][AW-1:0]      raddr_s;
    logic [1:0][N-1:0]       rdata_s;
    logic [1:0]              busy_s;

    // An address is usable when it exists and is not the hard-wired zero register.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !(ZR_EN && (a == {AW{1'b0}}));
    endfunction

    assign wr_ok_s  = we && addr_valid(waddr);
    assign iss_ok_s = issue && addr_valid(issue_addr);
    assign raddr_s  = {raddr2, raddr1};

    // Next-state for the register array and the pending vector; issue is applied last so it wins a collision.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_ok_s) begin
            regs_d[waddr]    = wdata;
            pending_d[waddr] = 1'b0;
        end else begin
            regs_d    = regs_q;
        end
        if (iss_ok_s) begin
            pending_d[issue_addr] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // State flops; reset drops all register contents and every pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= {(DEPTH * N){1'b0}};
            pending_q <= {DEPTH{1'b0}};
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    // Combinational read ports and per-port busy flags.
    always_comb begin
        rdata_s = {(2 * N){1'b0}};
        busy_s  = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (addr_valid(raddr_s[k])) begin
                rdata_s[k] = regs_q[raddr_s[k]];
                busy_s[k]  = pending_q[raddr_s[k]];
            end else begin
                rdata_s[k] = {N{1'b0}};
                busy_s[k]  = 1'b0;
            end
`ifdef REGS_BYPASS_EN
            // Forward the write-back value; a same-cycle re-issue keeps the register busy.
            if (wr_ok_s && (waddr == raddr_s[k])) begin
                rdata_s[k] = wdata;
                busy_s[k]  = iss_ok_s && (issue_addr == raddr_s[k]);
            end else begin
                rdata_s[k] = rdata_s[k];
                busy_s[k]  = busy_s[k];
            end
`else
            if (wr_ok_s && (waddr == raddr_s[k])) begin
                rdata_s[k] = rdata_s[k];
            end else begin
                rdata_s[k] = rdata_s[k];
            end
`endif
        end
    end

    assign rdata1 = rdata_s[0];
    assign rdata2 = rdata_s[1];
    assign busy1  = busy_s[0];
    assign busy2  = busy_s[1];
    assign stall  = busy_s[0] | busy_s[1];
    assign tap0   = regs_q[TAP0_A];
    assign tap1   = regs_q[TAP1_A];

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb: a behavioural array model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_sb;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                clk = 1'b0;
    logic                reset, we, issue;
    logic [AW-1:0]       waddr, raddr1, raddr2, issue_addr;
    logic [N-1:0]        wdata;
    logic signed [N-1:0] rdata1, rdata2, tap0, tap1;
    logic                busy1, busy2, stall;

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] m_reg [DEPTH];
    bit           m_pend[DEPTH];
    bit           chk_en = 1'b0;

    regfile_sb dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .issue(issue), .issue_addr(issue_addr), .busy1(busy1), .busy2(busy2),
        .stall(stall), .tap0(tap0), .tap1(tap1)
    );

    always #5 clk = ~clk;

    // Register 0 is the zero register; every 2-bit address exists.
    function automatic bit valid(int a);
        return (a < DEPTH) && (a != 0);
    endfunction

    function automatic bit fwd_hit(int a);
`ifdef REGS_BYPASS_EN
        return we && valid(waddr) && (int'(waddr) == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [N-1:0] exp_rd(int a);
        if (fwd_hit(a)) return wdata;
        if (!valid(a)) return 8'h00;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(int a);
        if (fwd_hit(a)) return issue && valid(issue_addr) && (int'(issue_addr) == a);
        if (!valid(a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic cmp(string nm, logic [N-1:0] act, logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update: mirrors the architectural effect of each clock edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[i]  = 8'h00;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && valid(waddr)) begin
                m_reg[waddr]  = wdata;
                m_pend[waddr] = 1'b0;
            end
            if (issue && valid(issue_addr)) m_pend[issue_addr] = 1'b1;
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rdata1", rdata1, exp_rd(raddr1));
            cmp("rdata2", rdata2, exp_rd(raddr2));
            cmp("busy1", {7'd0, busy1}, {7'd0, exp_busy(raddr1)});
            cmp("busy2", {7'd0, busy2}, {7'd0, exp_busy(raddr2)});
            cmp("stall", {7'd0, stall}, {7'd0, exp_busy(raddr1) | exp_busy(raddr2)});
            cmp("tap0", tap0, m_reg[2]);
            cmp("tap1", tap1, m_reg[3]);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = 8'h00;
            m_pend[i] = 1'b0;
        end
        reset = 1'b1; we = 1'b0; issue = 1'b0;
        waddr = 2'd0; wdata = 8'h00; raddr1 = 2'd0; raddr2 = 2'd0; issue_addr = 2'd0;
        tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // 1. reset clears a preloaded register
        we = 1'b1; waddr = 2'd1; wdata = 8'h55; issue = 1'b1; issue_addr = 2'd3;
        tick();
        we = 1'b0; issue = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; raddr1 = 2'd1; raddr2 = 2'd3;
        @(negedge clk);
        cmp("t1_rdata1", rdata1, 8'h00);
        cmp("t1_tap0", tap0, 8'h00);
        cmp("t1_tap1", tap1, 8'h00);
        cmp("t1_stall", {7'd0, stall}, 8'h00);
        tick();

        // 2. write then read, signed view
        we = 1'b1; waddr = 2'd2; wdata = 8'hF3; raddr2 = 2'd2;
        tick();
        we = 1'b0;
        @(negedge clk);
        cmp("t2_rdata2", rdata2, 8'hF3);
        cmp("t2_signed", (int'(rdata2) == -13) ? 8'h01 : 8'h00, 8'h01);
        cmp("t2_tap0", tap0, 8'hF3);
        tick();

        // 3. zero register ignores writes and issues
        we = 1'b1; waddr = 2'd0; wdata = 8'h7F; issue = 1'b1; issue_addr = 2'd0; raddr1 = 2'd0;
        tick();
        we = 1'b0; issue = 1'b0;
        @(negedge clk);
        cmp("t3_rdata1", rdata1, 8'h00);
        cmp("t3_busy1", {7'd0, busy1}, 8'h00);
        tick();

        // 4. scoreboard: pending until written back
        issue = 1'b1; issue_addr = 2'd3;
        tick();
        issue = 1'b0; raddr1 = 2'd3; raddr2 = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("t4_busy1", {7'd0, busy1}, 8'h01);
            cmp("t4_stall", {7'd0, stall}, 8'h01);
            tick();
        end
        we = 1'b1; waddr = 2'd3; wdata = 8'h10;
        tick();
        we = 1'b0;
        @(negedge clk);
        cmp("t4_busy1_clr", {7'd0, busy1}, 8'h00);
        cmp("t4_rdata1", rdata1, 8'h10);
        tick();

        // 5. same-cycle issue and write-back: written and still pending
        issue = 1'b1; issue_addr = 2'd1; we = 1'b1; waddr = 2'd1; wdata = 8'h22;
        tick();
        issue = 1'b0; we = 1'b0; raddr1 = 2'd1;
        @(negedge clk);
        cmp("t5_rdata1", rdata1, 8'h22);
        cmp("t5_busy1", {7'd0, busy1}, 8'h01);
        tick();

        // 6. write-cycle read of the written register
        we = 1'b1; waddr = 2'd2; wdata = 8'h44; raddr1 = 2'd2;
        @(negedge clk);
`ifdef REGS_BYPASS_EN
        cmp("t6_same", rdata1, 8'h44);
`else
        cmp("t6_same", rdata1, 8'hF3);
`endif
        tick();
        we = 1'b0;
        @(negedge clk);
        cmp("t6_next", rdata1, 8'h44);
        tick();

        // Randomised traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 49) == 0);
            we         = $urandom_range(0, 1);
            issue      = ($urandom_range(0, 3) == 0);
            waddr      = AW'($urandom_range(0, DEPTH - 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            wdata      = N'($urandom);
            raddr1     = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            raddr2     = AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        reset = 1'b0; we = 1'b0; issue = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
